// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding-request
// imem handshake, and buffers one instruction for the IF/ID register.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall[5:0]                 ctrl stall vector (bit0 IF hold, bit2 ID hold)
//   flush, new_pc              exception flush and its target PC
//   branch_flag_i              taken branch reported by ID
//   branch_target_address_i    branch target from ID
//   imem_req/addr/ack/rdata    instruction-memory handshake
//   if_pc, if_inst             buffered instruction presented to IF/ID
//   stallreq                   asserted while no instruction is buffered
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] INIT_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              stallreq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              buf_full_q, buf_full_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [DATA_W-1:0] buf_inst_q, buf_inst_d;
    logic              br_pend_q, br_pend_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic [ADDR_W-1:0] drop_tgt_q, drop_tgt_d;

    logic consume;
    logic accept;
    logic redir;
    logic req;
    logic [ADDR_W-1:0] addr;

    // Only the IF and ID hold bits matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[1]};

    assign consume = buf_full_q & ~stall[0];
    assign accept  = ~buf_full_q | consume;
    assign redir   = branch_flag_i & ~stall[2];

    always_comb begin
        req  = 1'b0;
        addr = pc_q;
        unique case (state_q)
            S_IDLE: begin
                req  = accept & ~flush;
                addr = redir ? branch_target_address_i : pc_q;
            end
            S_WAIT, S_DROP: begin
                req  = 1'b1;
                addr = pc_q;
            end
            default: begin
                req  = 1'b0;
                addr = pc_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_full_d = buf_full_q & ~consume;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;
        drop_tgt_d = drop_tgt_q;

        if (flush) begin
            buf_full_d = 1'b0;
            br_pend_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    pc_d = new_pc;
                end else if (req && imem_ack) begin
                    buf_full_d = 1'b1;
                    buf_pc_d   = addr;
                    buf_inst_d = imem_rdata;
                    pc_d       = addr + PC_STEP;
                end else if (req) begin
                    pc_d    = addr;
                    state_d = S_WAIT;
                end else if (redir) begin
                    pc_d = branch_target_address_i;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    if (imem_ack) begin
                        pc_d    = new_pc;
                        state_d = S_IDLE;
                    end else begin
                        drop_tgt_d = new_pc;
                        state_d    = S_DROP;
                    end
                end else if (imem_ack) begin
                    // In-flight word is the delay slot; a branch seen
                    // this cycle or earlier steers the next fetch.
                    buf_full_d = 1'b1;
                    buf_pc_d   = pc_q;
                    buf_inst_d = imem_rdata;
                    br_pend_d  = 1'b0;
                    if (redir)
                        pc_d = branch_target_address_i;
                    else if (br_pend_q)
                        pc_d = br_tgt_q;
                    else
                        pc_d = pc_q + PC_STEP;
                    state_d = S_IDLE;
                end else if (redir) begin
                    br_pend_d = 1'b1;
                    br_tgt_d  = branch_target_address_i;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    pc_d    = flush ? new_pc : drop_tgt_q;
                    state_d = S_IDLE;
                end else if (flush) begin
                    drop_tgt_d = new_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= INIT_ADDR;
            buf_full_q <= 1'b0;
            buf_pc_q   <= INIT_ADDR;
            buf_inst_q <= '0;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= INIT_ADDR;
            drop_tgt_q <= INIT_ADDR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_full_q <= buf_full_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
            drop_tgt_q <= drop_tgt_d;
        end
    end

    // Outputs are forced to reset values while rst is held.
    assign imem_req  = ~rst & req;
    assign imem_addr = addr;
    assign if_pc     = rst ? INIT_ADDR : buf_pc_q;
    assign if_inst   = (~rst & buf_full_q) ? buf_inst_q : '0;
    assign stallreq  = ~rst & ~buf_full_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch.
// Memory model answers combinationally; ack is scripted per cycle.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq                (stallreq)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h20)
            return 32'hDEAD_BEEF;
        return a ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_rdata = memf(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after inputs change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = '0;
        flush = 1'b0;
        new_pc = '0;
        branch_flag_i = 1'b0;
        branch_target_address_i = '0;
        imem_ack = 1'b1;

        // 1. reset and zero-wait streaming
        settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        cyc();
        chk("rst2_req", 32'(imem_req), 32'd0);
        chk("rst2_inst", if_inst, 32'h0);
        cyc();
        rst = 1'b0;
        settle();
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_stallreq", 32'(stallreq), 32'd1);
        cyc();
        chk("s1_addr", imem_addr, 32'h4);
        chk("s1_pc", if_pc, 32'h0);
        chk("s1_inst", if_inst, memf(32'h0));
        chk("s1_stallreq", 32'(stallreq), 32'd0);
        cyc();
        chk("s2_addr", imem_addr, 32'h8);
        chk("s2_pc", if_pc, 32'h4);
        chk("s2_inst", if_inst, memf(32'h4));

        // 2. wait states at 0x10
        cyc();
        flush = 1'b1;
        new_pc = 32'h10;
        settle();
        chk("fl10_req", 32'(imem_req), 32'd0);
        cyc();
        flush = 1'b0;
        imem_ack = 1'b0;
        settle();
        chk("w0_addr", imem_addr, 32'h10);
        chk("w0_req", 32'(imem_req), 32'd1);
        chk("w0_stallreq", 32'(stallreq), 32'd1);
        chk("w0_inst", if_inst, 32'h0);
        cyc();
        chk("w1_addr", imem_addr, 32'h10);
        chk("w1_stallreq", 32'(stallreq), 32'd1);
        chk("w1_inst", if_inst, 32'h0);
        cyc();
        imem_ack = 1'b1;
        settle();
        chk("w2_addr", imem_addr, 32'h10);
        chk("w2_stallreq", 32'(stallreq), 32'd1);
        cyc();
        chk("w3_pc", if_pc, 32'h10);
        chk("w3_inst", if_inst, memf(32'h10));
        chk("w3_stallreq", 32'(stallreq), 32'd0);

        // 3. stall hold on 0x20
        cyc();
        flush = 1'b1;
        new_pc = 32'h20;
        cyc();
        flush = 1'b0;
        settle();
        chk("h0_addr", imem_addr, 32'h20);
        cyc();
        stall = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_pc", if_pc, 32'h20);
            chk("hold_inst", if_inst, 32'hDEAD_BEEF);
            chk("hold_req", 32'(imem_req), 32'd0);
            cyc();
        end
        stall = '0;
        settle();
        chk("res_req", 32'(imem_req), 32'd1);
        chk("res_addr", imem_addr, 32'h24);
        chk("res_inst", if_inst, 32'hDEAD_BEEF);

        // 4. branch at 0x40, delay slot 0x44 in WAIT
        cyc();
        flush = 1'b1;
        new_pc = 32'h40;
        cyc();
        flush = 1'b0;
        imem_ack = 1'b1;
        settle();
        chk("b0_addr", imem_addr, 32'h40);
        cyc();
        imem_ack = 1'b0;
        settle();
        chk("b1_addr", imem_addr, 32'h44);
        chk("b1_pc", if_pc, 32'h40);
        cyc();
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h100;
        settle();
        chk("b2_addr", imem_addr, 32'h44);
        chk("b2_stallreq", 32'(stallreq), 32'd1);
        cyc();
        branch_flag_i = 1'b0;
        imem_ack = 1'b1;
        settle();
        chk("b3_addr", imem_addr, 32'h44);
        cyc();
        chk("ds_pc", if_pc, 32'h44);
        chk("ds_inst", if_inst, memf(32'h44));
        chk("tgt_addr", imem_addr, 32'h100);

        // 5. flush while 0x50 is outstanding
        cyc();
        flush = 1'b1;
        new_pc = 32'h50;
        cyc();
        flush = 1'b0;
        imem_ack = 1'b0;
        settle();
        chk("f0_addr", imem_addr, 32'h50);
        cyc();
        flush = 1'b1;
        new_pc = 32'h180;
        settle();
        chk("f1_req", 32'(imem_req), 32'd1);
        chk("f1_addr", imem_addr, 32'h50);
        cyc();
        flush = 1'b0;
        settle();
        chk("f2_addr", imem_addr, 32'h50);
        chk("f2_req", 32'(imem_req), 32'd1);
        chk("f2_inst", if_inst, 32'h0);
        cyc();
        imem_ack = 1'b1;
        settle();
        chk("f3_addr", imem_addr, 32'h50);
        cyc();
        imem_ack = 1'b0;
        settle();
        chk("f4_addr", imem_addr, 32'h180);
        chk("f4_inst", if_inst, 32'h0);
        chk("f4_stallreq", 32'(stallreq), 32'd1);

        // 6a. flush coincident with ack in WAIT
        cyc();
        flush = 1'b1;
        new_pc = 32'h200;
        imem_ack = 1'b1;
        settle();
        chk("fa_req", 32'(imem_req), 32'd1);
        chk("fa_addr", imem_addr, 32'h180);
        cyc();
        flush = 1'b0;
        settle();
        chk("fa1_inst", if_inst, 32'h0);
        chk("fa1_stallreq", 32'(stallreq), 32'd1);
        chk("fa1_addr", imem_addr, 32'h200);

        // 6b. PC wrap
        cyc();
        flush = 1'b1;
        new_pc = 32'hFFFF_FFFC;
        settle();
        chk("wr0_pc", if_pc, 32'h200);
        chk("wr0_inst", if_inst, memf(32'h200));
        cyc();
        flush = 1'b0;
        settle();
        chk("wr1_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wr2_addr", imem_addr, 32'h0);
        chk("wr2_pc", if_pc, 32'hFFFF_FFFC);
        chk("wr2_inst", if_inst, memf(32'hFFFF_FFFC));

        // reset mid-run forces reset outputs at once
        rst = 1'b1;
        settle();
        chk("rr_req", 32'(imem_req), 32'd0);
        chk("rr_pc", if_pc, 32'h0);
        chk("rr_inst", if_inst, 32'h0);
        chk("rr_stallreq", 32'(stallreq), 32'd0);
        cyc();
        rst = 1'b0;
        settle();
        chk("rr1_addr", imem_addr, 32'h0);
        chk("rr1_stallreq", 32'(stallreq), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
